sipo_word_packer: RTL

- Serial-in/parallel-out stage directly downstream of the enable-gated D flip-flop.
- Consumes the flop's registered bit stream, qualified by the same enable strobe.
- Packs WIDTH bits into a word and presents it on a valid/ready output port.
- Includes a bit counter, a one-word output buffer, an overrun flag and a synchronous realign input.

---
 rtl/sipo_word_packer.sv | 101 ++++++++++
 1 files changed

// File: rtl/sipo_word_packer.sv
// Packs en-qualified serial bits into WIDTH-bit words; word valid one cycle after its last bit.
// One-word output buffer: refills on the handshake edge; with ready low a completed word is dropped and overrun set.
module sipo_word_packer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     din,
  input  logic                     clr,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     overrun
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovr_q, ovr_d;

  logic             shift_en;
  logic             complete;
  logic [WIDTH-1:0] sr_shift;

  always_comb begin
    shift_en = en && !clr;
    sr_shift = MSB_FIRST ? {sr_q[WIDTH-2:0], din} : {din, sr_q[WIDTH-1:1]};
    complete = shift_en && (cnt_q == CW'(WIDTH - 1));
  end

  // Shift register, bit counter and sticky overrun; clr wins over any bit in the same cycle.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    ovr_d = ovr_q;
    if (clr) begin
      sr_d  = '0;
      cnt_d = '0;
      ovr_d = 1'b0;
    end else if (en) begin
      sr_d  = sr_shift;
      cnt_d = complete ? '0 : cnt_q + CW'(1);
    end
    if (complete && state_q == FULL && !dout_ready) begin
      ovr_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    case (state_q)
      EMPTY: begin
        if (complete) begin
          state_d = FULL;
          dout_d  = sr_shift;
        end
      end
      FULL: begin
        if (dout_ready) begin
          if (complete) begin
            dout_d = sr_shift;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      sr_q    <= '0;
      dout_q  <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = (state_q == FULL);
  assign bit_cnt    = cnt_q;
  assign overrun    = ovr_q;

endmodule
